cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU32 datapath.
- Operands are split into BLK-bit carry-lookahead groups. Each pipeline stage resolves BLKS_PER_STAGE groups, and the carry ripples stage to stage.
- A valid/ready handshake on both sides gives one result per cycle at full throughput.
- Keeps the enable-gating semantics of the existing gate-level adders: when disabled, results are forced to zero.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/cla_block.sv | 51 +++++
 rtl/cla_pipe_adder.sv | 145 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants and helpers for the ALU32 adder datapath.
// Revision    : 1.0
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int CLA_BLK   = 4;

    localparam logic c_MODE_ADD = 1'b0;
    localparam logic c_MODE_SUB = 1'b1;

    function automatic int calc_stages(input int width, input int blk, input int blks_per_stage);
        return width / (blk * blks_per_stage);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_block.sv
`default_nettype none
// ============================================================================
// Module      : cla_block
// Description : BLK-bit carry-lookahead group with group generate/propagate.
// Revision    : 1.0
// ============================================================================
module cla_block
    import alu_pkg::*;
#(
    parameter int BLK = CLA_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] sum,
    output logic           g,
    output logic           p,
    output logic           cmsb
);

    logic [BLK-1:0] w_g;
    logic [BLK-1:0] w_p;
    logic [BLK:0]   w_gen;
    logic [BLK:0]   w_pp;
    logic [BLK-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each bit carry is G[i-1:0] | P[i-1:0] & ci, so ci fans out directly.
    always_comb begin
        w_gen    = '0;
        w_pp     = '0;
        w_c      = '0;
        w_pp[0]  = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            w_gen[i+1] = w_g[i] | (w_p[i] & w_gen[i]);
            w_pp[i+1]  = w_p[i] & w_pp[i];
        end
        for (int i = 0; i < BLK; i++) begin
            w_c[i] = w_gen[i] | (w_pp[i] & ci);
        end
    end

    assign sum  = w_p ^ w_c;
    assign g    = w_gen[BLK];
    assign p    = w_pp[BLK];
    assign cmsb = w_c[BLK-1];

endmodule
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_adder
// Description : Pipelined carry-lookahead adder/subtractor, valid/ready both sides.
// Revision    : 1.0
// ============================================================================
module cla_pipe_adder
    import alu_pkg::*;
#(
    parameter int WIDTH          = ALU_WIDTH,
    parameter int BLK            = CLA_BLK,
    parameter int BLKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SW     = BLK * BLKS_PER_STAGE;
    localparam int STAGES = calc_stages(WIDTH, BLK, BLKS_PER_STAGE);
    localparam int LAST   = STAGES - 1;

    if (WIDTH % SW != 0) begin : g_width_check
        $error("cla_pipe_adder: WIDTH must be a multiple of BLK*BLKS_PER_STAGE");
    end

    logic             r_v   [STAGES];
    logic             r_c   [STAGES];
    logic             r_en  [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];

    logic [WIDTH-1:0] w_snext   [STAGES];
    logic             w_cout_st [STAGES];
    logic             w_cmsb_st [STAGES];

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance && !rst;
    assign w_b_eff   = (in_sub == c_MODE_SUB) ? ~in_b : in_b;
    assign w_c0      = (in_sub == c_MODE_SUB) ? 1'b1 : in_cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [BLKS_PER_STAGE:0]   w_gc;
        logic [BLKS_PER_STAGE-1:0] w_gg;
        logic [BLKS_PER_STAGE-1:0] w_gp;
        logic [BLKS_PER_STAGE-1:0] w_cm;
        logic [SW-1:0]             w_sum;

        for (genvar j = 0; j < BLKS_PER_STAGE; j++) begin : g_grp
            localparam int LSB = k * SW + j * BLK;
            cla_block #(.BLK(BLK)) u_cla (
                .a    (r_a[k][LSB +: BLK]),
                .b    (r_b[k][LSB +: BLK]),
                .ci   (w_gc[j]),
                .sum  (w_sum[j*BLK +: BLK]),
                .g    (w_gg[j]),
                .p    (w_gp[j]),
                .cmsb (w_cm[j])
            );
        end

        // Group-level chaining inside the stage; the stage carry then ripples on.
        always_comb begin
            w_gc    = '0;
            w_gc[0] = r_c[k];
            for (int j = 0; j < BLKS_PER_STAGE; j++) begin
                w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
            end
        end

        assign w_cout_st[k] = w_gc[BLKS_PER_STAGE];
        assign w_cmsb_st[k] = w_cm[BLKS_PER_STAGE-1];
        assign w_snext[k]   = r_s[k] | (WIDTH'(w_sum) << (k * SW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]  <= 1'b0;
                r_c[k]  <= 1'b0;
                r_en[k] <= 1'b0;
                r_a[k]  <= '0;
                r_b[k]  <= '0;
                r_s[k]  <= '0;
            end
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_advance) begin
            r_v[0]  <= in_valid;
            r_a[0]  <= in_a;
            r_b[0]  <= w_b_eff;
            r_c[0]  <= w_c0;
            r_en[0] <= in_en;
            r_s[0]  <= '0;
            for (int k = 1; k < STAGES; k++) begin
                r_v[k]  <= r_v[k-1];
                r_a[k]  <= r_a[k-1];
                r_b[k]  <= r_b[k-1];
                r_c[k]  <= w_cout_st[k-1];
                r_en[k] <= r_en[k-1];
                r_s[k]  <= w_snext[k-1];
            end
            // Disabled transactions still emit, with result and every flag gated to zero.
            r_out_valid <= r_v[LAST];
            r_sum       <= r_en[LAST] ? w_snext[LAST] : '0;
            r_cout      <= r_en[LAST] & w_cout_st[LAST];
            r_ovf       <= r_en[LAST] & (w_cmsb_st[LAST] ^ w_cout_st[LAST]);
            r_zero      <= r_en[LAST] & (w_snext[LAST] == '0);
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;
    assign out_zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe_adder
// Description : Self-checking bench: directed vector table, stall/reset sequences, random scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_cla_pipe_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_cin, in_sub, in_en;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [W-1:0] out_sum;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic         en;
        res_t         exp;
    } vec_t;

    cla_pipe_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: unsigned 33-bit sum for carry, true signed arithmetic for overflow.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input logic en);
        res_t               r;
        logic [W:0]         f;
        logic signed [W+1:0] sa, sb, sc, t;
        sa = $signed(a);
        sb = $signed(b);
        sc = {{(W+1){1'b0}}, cin};
        if (sub) begin
            f = {1'b0, a} + {1'b0, ~b} + 33'd1;
            t = sa - sb;
        end else begin
            f = {1'b0, a} + {1'b0, b} + {32'b0, cin};
            t = sa + sb + sc;
        end
        r.sum  = f[W-1:0];
        r.cout = f[W];
        r.ovf  = (t > 34'sd2147483647) || (t < -34'sd2147483648);
        r.zero = (f[W-1:0] == '0);
        if (!en) r = '0;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted op must come out, in order, matching the model.
    res_t exp_q[$];
    res_t sb_e;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: actual=output sum %h required=no output", out_sum);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_result", {29'b0, out_sum, out_cout, out_ovf, out_zero}, {29'b0, sb_e});
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_a, in_b, in_cin, in_sub, in_en));
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic en);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_en    = en;
    endtask

    // One isolated transaction: checks latency and result against the table entry.
    task automatic run_vec(input vec_t v, input string nm);
        int acc_edge;
        int lat;
        @(posedge clk); #1;
        drive(v.a, v.b, v.cin, v.sub, v.en);
        @(negedge clk);
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        acc_edge = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        lat = cyc - acc_edge;
        check({nm, "_latency"}, 64'(lat), 64'd4);
        check({nm, "_result"}, {29'b0, out_sum, out_cout, out_ovf, out_zero}, {29'b0, v.exp});
    endtask

    vec_t vecs[12];
    int   ones;

    initial begin
        vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
        vecs[2]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
        vecs[3]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 1'b1, '{32'h00000002, 1'b1, 1'b0, 1'b0}};
        vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, '{32'h00000000, 1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b1, 1'b1}};
        vecs[6]  = '{32'h0000000F, 32'h00000000, 1'b1, 1'b0, 1'b1, '{32'h00000010, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b1, '{32'h00000100, 1'b0, 1'b0, 1'b0}};
        vecs[8]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
        vecs[9]  = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        vecs[10] = '{32'h12345678, 32'hEDCBA988, 1'b0, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
        vecs[11] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, '{32'h00000000, 1'b0, 1'b0, 1'b0}};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; in_en = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_outputs", {28'b0, out_valid, out_sum, out_cout, out_ovf, out_zero}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back ops with the consumer stalled after the first result.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(W'(i), W'(i), 1'b0, 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        for (int i = 0; i < 3; i++) begin
            check("stall_hold_sum", {out_valid, out_sum}, {1'b1, 32'd2});
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("release_seq", {out_valid, out_sum}, {1'b1, W'(2 * k)});
            @(negedge clk);
        end
        check("release_drained", 64'(out_valid), 64'd0);

        // Reset with two ops in flight: nothing may emerge afterwards.
        @(posedge clk); #1;
        drive(32'd10, 32'd20, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(32'd30, 32'd40, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midreset_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) ones++;
        end
        check("midreset_no_output", 64'(ones), 64'd0);
        run_vec('{32'd100, 32'd23, 1'b0, 1'b0, 1'b1, '{32'd123, 1'b0, 1'b0, 1'b0}}, "post_reset");

        // Random traffic with random backpressure, checked by the scoreboard.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       in_a = 32'hFFFFFFFF;
                1:       in_a = 32'h7FFFFFFF;
                2:       in_a = 32'h80000000;
                default: in_a = $urandom;
            endcase
            in_b   = ($urandom_range(0, 4) == 0) ? in_a : $urandom;
            in_cin = $urandom_range(0, 1) == 1;
            in_sub = $urandom_range(0, 1) == 1;
            in_en  = $urandom_range(0, 7) != 0;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("random_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
